// File: rtl/addsub_ovf_seq.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per cycle LSB first,
// with overflow/carry/zero/negative flags and a sticky overflow bit.
module addsub_ovf_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             ovf_sticky,
    input  logic             clr_sticky,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in DONE, and the
    // result/flags stay frozen there until out_ready is seen.
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
    logic             a_msb_q, b_msb_q, carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overflow_q, carry_out_q, zero_q, negative_q, sticky_q;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] b_eff;
    logic             ovf_d;

    always_comb begin
        b_eff     = sub ? ~op_b : op_b;
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                    + (CHUNK+1)'(carry_q);
        // New chunk enters at the top; after NCHUNK shifts acc holds the sum.
        acc_d     = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        ovf_d     = (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= b_eff;
                        a_msb_q <= op_a[WIDTH-1];
                        b_msb_q <= b_eff[WIDTH-1];
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_sum[CHUNK];
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        result_q    <= acc_d;
                        carry_out_q <= chunk_sum[CHUNK];
                        overflow_q  <= ovf_d;
                        zero_q      <= (acc_d == '0);
                        negative_q  <= acc_d[WIDTH-1];
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Set has priority over clear when both land in the same cycle.
            if (state_q == DONE && out_ready && overflow_q) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign carry_out  = carry_out_q;
    assign zero       = zero_q;
    assign negative   = negative_q;
    assign ovf_sticky = sticky_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_addsub_ovf_seq.sv
// Bench for addsub_ovf_seq: vector table, random ops against a reference
// model through an expected-result queue, plus backpressure/sticky/reset cases.
module tb_addsub_ovf_seq;

    localparam int W      = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = W / CHUNK;
    localparam int EW     = W + 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a, op_b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          overflow, carry_out, zero, negative, ovf_sticky;
    logic          clr_sticky;
    logic [1:0]    state_dbg;

    addsub_ovf_seq #(.WIDTH(W), .CHUNK(CHUNK)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .carry_out(carry_out),
        .zero(zero), .negative(negative),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    // Expected word layout: {result, overflow, carry_out, zero, negative}
    logic [EW-1:0] exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic sticky_exp = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         ovf, cout, z, n;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        logic [W-1:0] be;
        logic [W:0]   sum;
        logic [W-1:0] r;
        logic         ovf;
        be  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, be} + (W+1)'(s);
        r   = sum[W-1:0];
        ovf = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return {r, ovf, sum[W], (r == '0), r[W-1]};
    endfunction

    task automatic check_outputs(input string tag, input logic [EW-1:0] e);
        check({tag, ".result"}, 64'(result), 64'(e[EW-1:4]));
        check({tag, ".overflow"}, 64'(overflow), 64'(e[3]));
        check({tag, ".carry_out"}, 64'(carry_out), 64'(e[2]));
        check({tag, ".zero"}, 64'(zero), 64'(e[1]));
        check({tag, ".negative"}, 64'(negative), 64'(e[0]));
    endtask

    // Issue one op, wait for the result, hold backpressure, then deliver it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [EW-1:0] e_push, input int hold, input logic clr_hs,
                          input string tag);
        int guard;
        int lat;
        logic [EW-1:0] e;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        exp_q.push_back(e_push);
        @(negedge clock);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(NCHUNK));
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.queue: got empty expected one entry", tag);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_outputs(tag, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_word"},
                  64'({result, overflow, carry_out, zero, negative}), 64'(e));
        end
        out_ready = 1'b1;
        clr_sticky = clr_hs;
        if (e[3]) sticky_exp = 1'b1;
        else if (clr_hs) sticky_exp = 1'b0;
        @(negedge clock);
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".sticky"}, 64'(ovf_sticky), 64'(sticky_exp));
        check({tag, ".result_kept"}, 64'(result), 64'(e[EW-1:4]));
    endtask

    initial begin
        vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        repeat (3) @(negedge clock);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check_outputs("reset", '0);
        check("reset.sticky", 64'(ovf_sticky), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s,
                   {vecs[i].r, vecs[i].ovf, vecs[i].cout, vecs[i].z, vecs[i].n},
                   i % 3, 1'b0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), $urandom_range(0, 2), 1'b0,
                   $sformatf("rnd%0d", i));
        end

        // Clear sticky, then an overflow result under backpressure, delivered
        // together with a clear request.
        clr_sticky = 1'b1;
        @(negedge clock);
        clr_sticky = 1'b0;
        sticky_exp = 1'b0;
        check("clr.sticky", 64'(ovf_sticky), 64'd0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, model(32'h7FFF_FFFF, 32'h1, 1'b0),
               10, 1'b1, "bp");
        clr_sticky = 1'b1;
        @(negedge clock);
        clr_sticky = 1'b0;
        sticky_exp = 1'b0;
        check("clr_alone.sticky", 64'(ovf_sticky), 64'd0);

        // Overflow again so sticky is set, then reset in the 2nd CALC cycle.
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, model(32'h8000_0000, 32'h1, 1'b1),
               0, 1'b0, "pre_rst");
        op_a = 32'h1111_1111; op_b = 32'h2222_2222; sub = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check("mid.state_calc", 64'(out_valid), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sticky_exp = 1'b0;
        check("mid_rst.in_ready", 64'(in_ready), 64'd1);
        check("mid_rst.out_valid", 64'(out_valid), 64'd0);
        check_outputs("mid_rst", '0);
        check("mid_rst.sticky", 64'(ovf_sticky), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, {32'd7, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 1'b0, "post_rst");

        check("final.queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
